// File: rtl/mem_data_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port, fixed-latency data memory.
// Writes complete in the grant cycle. Reads hold the memory address for MEM_LAT cycles.
// The read result is then returned to the requester that issued the read.
module mem_data_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            r0_req,
  input  logic            r0_we,
  input  logic [XLEN-1:0] r0_addr,
  input  logic [XLEN-1:0] r0_wdata,
  output logic            r0_gnt,
  output logic            r0_rvalid,
  output logic [XLEN-1:0] r0_rdata,

  input  logic            r1_req,
  input  logic            r1_we,
  input  logic [XLEN-1:0] r1_addr,
  input  logic [XLEN-1:0] r1_wdata,
  output logic            r1_gnt,
  output logic            r1_rvalid,
  output logic [XLEN-1:0] r1_rdata,

  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_data,
  output logic            mem_iWrite,
  input  logic [XLEN-1:0] mem_out,

  output logic            busy
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              rr_last_q;   // requester granted most recently
  logic [XLEN-1:0]   rd_addr_q;
  logic              rd_owner_q;

  logic              sel_valid;
  logic              sel;         // 0 = r0, 1 = r1
  logic              sel_we;
  logic [XLEN-1:0]   sel_addr;
  logic [XLEN-1:0]   sel_wdata;

  // Winner selection: only in IDLE and never while reset is asserted.
  always_comb begin
    sel_valid = 1'b0;
    sel       = 1'b0;
    if (!reset && state_q == StIdle) begin
      if (r0_req && r1_req) begin
        sel_valid = 1'b1;
        sel       = ~rr_last_q;
      end else if (r0_req) begin
        sel_valid = 1'b1;
        sel       = 1'b0;
      end else if (r1_req) begin
        sel_valid = 1'b1;
        sel       = 1'b1;
      end
    end
    sel_we    = sel ? r1_we    : r0_we;
    sel_addr  = sel ? r1_addr  : r0_addr;
    sel_wdata = sel ? r1_wdata : r0_wdata;
  end

  // Grant pulses and memory-side drive.
  always_comb begin
    r0_gnt      = sel_valid && !sel;
    r1_gnt      = sel_valid && sel;
    mem_address = '0;
    mem_data    = '0;
    mem_iWrite  = 1'b0;
    if (state_q == StRdWait) begin
      mem_address = rd_addr_q;
    end else if (sel_valid) begin
      mem_address = sel_addr;
      mem_data    = sel_wdata;
      mem_iWrite  = sel_we;
    end
    busy = (state_q == StRdWait);
  end

  // Arbitration state, read sequencing and registered read responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rr_last_q  <= 1'b1;
      rd_addr_q  <= '0;
      rd_owner_q <= 1'b0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sel_valid) begin
            rr_last_q <= sel;
            if (!sel_we) begin
              rd_addr_q  <= sel_addr;
              rd_owner_q <= sel;
              cnt_q      <= CW'(1);
              state_q    <= StRdWait;
            end
          end
        end
        StRdWait: begin
          if (cnt_q == CW'(MEM_LAT)) begin
            if (rd_owner_q) begin
              r1_rdata  <= mem_out;
              r1_rvalid <= 1'b1;
            end else begin
              r0_rdata  <= mem_out;
              r0_rvalid <= 1'b1;
            end
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
